// File: rtl/slice_collector.sv
// slice_collector: packs a bit-serial result stream into 25-bit slices tagged with a 6-bit line
// number (64 slices per frame). Define SLICE_PARITY_EN to add slice_parity_o.
module slice_collector (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        bit_valid_i,
    input  logic        bit_in_i,
    output logic        bit_ready_o,
    output logic [24:0] slice_out_o,
    output logic [5:0]  line_number_o,
    output logic        slice_valid_o,
    input  logic        slice_ready_i,
    output logic        busy_o,
`ifdef SLICE_PARITY_EN
    output logic        slice_parity_o,
`endif
    output logic        done_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StHold    = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  slice_cnt_q, slice_cnt_d;
    logic [24:0] slice_q, slice_d;
`ifdef SLICE_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        slice_cnt_d = slice_cnt_q;
        slice_d     = slice_q;
`ifdef SLICE_PARITY_EN
        parity_d    = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StCollect;
                    bit_cnt_d   = 5'd0;
                    slice_cnt_d = 6'd0;
                    slice_d     = 25'h0;
`ifdef SLICE_PARITY_EN
                    parity_d    = 1'b0;
`endif
                end
            end
            StCollect: begin
                if (bit_valid_i) begin
                    // First bit of a slice lands in the MSB.
                    slice_d[5'd24 - bit_cnt_q] = bit_in_i;
`ifdef SLICE_PARITY_EN
                    parity_d = parity_q ^ bit_in_i;
`endif
                    if (bit_cnt_q == 5'd24) begin
                        bit_cnt_d = 5'd0;
                        state_d   = StHold;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StHold: begin
                if (slice_ready_i) begin
                    if (slice_cnt_q == 6'd63) begin
                        state_d = StDone;
                    end else begin
                        slice_cnt_d = slice_cnt_q + 6'd1;
                        slice_d     = 25'h0;
`ifdef SLICE_PARITY_EN
                        parity_d    = 1'b0;
`endif
                        state_d     = StCollect;
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                slice_cnt_d = 6'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 5'd0;
            slice_cnt_q <= 6'd0;
            slice_q     <= 25'h0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            slice_cnt_q <= slice_cnt_d;
            slice_q     <= slice_d;
        end
    end

`ifdef SLICE_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign slice_parity_o = parity_q;
`endif

    // All outputs decode registered state only; no input reaches an output combinationally.
    assign bit_ready_o   = (state_q == StCollect);
    assign slice_valid_o = (state_q == StHold);
    assign busy_o        = (state_q == StCollect) || (state_q == StHold);
    assign done_o        = (state_q == StDone);
    assign slice_out_o   = slice_q;
    assign line_number_o = slice_cnt_q;

endmodule

// File: tb/tb_slice_collector.sv
// tb_slice_collector: table-driven frame scenarios plus hand-written reset, backpressure and
// start-ignore sequences for slice_collector. Parity checks apply when SLICE_PARITY_EN is defined.
module tb_slice_collector;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        bit_valid_i;
    logic        bit_in_i;
    logic        bit_ready_o;
    logic [24:0] slice_out_o;
    logic [5:0]  line_number_o;
    logic        slice_valid_o;
    logic        slice_ready_i;
    logic        busy_o;
    logic        done_o;
`ifdef SLICE_PARITY_EN
    logic        slice_parity_o;
`endif

    int checks = 0;
    int errors = 0;

    slice_collector dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .bit_valid_i   (bit_valid_i),
        .bit_in_i      (bit_in_i),
        .bit_ready_o   (bit_ready_o),
        .slice_out_o   (slice_out_o),
        .line_number_o (line_number_o),
        .slice_valid_o (slice_valid_o),
        .slice_ready_i (slice_ready_i),
        .busy_o        (busy_o),
`ifdef SLICE_PARITY_EN
        .slice_parity_o(slice_parity_o),
`endif
        .done_o        (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [24:0] data;        // bits sent per slice, MSB first
        bit          gaps;        // randomly drop bit_valid
        int          stall_slice; // slice held with slice_ready low (-1: none)
        int          stall_len;
        bit          start_mid;   // pulse start during COLLECT
        bit          abort;       // assert reset at slice 17, bit 12
        logic [24:0] exp_slice;
        logic        exp_par;
        int          exp_done;    // cycle of done after start (0: not checked)
    } vec_t;

    vec_t vecs[5];
    vec_t abort_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int          snd_slice = 0;
        int          bit_idx   = 0;
        int          rcv       = 0;
        int          stall_cnt = 0;
        bit          post_stall = 0;
        bit          seen_hold  = 0;
        bit          finished   = 0;
        bit          got_done   = 0;
        logic [24:0] held       = '0;

        @(negedge clk_i);
        start_i       = 1'b1;
        bit_valid_i   = 1'b0;
        slice_ready_i = 1'b1;
        for (int k = 1; k <= 6000 && !finished; k++) begin
            @(negedge clk_i);
            start_i = v.start_mid && (k == 10);
            if (post_stall) begin
                check("resume_bit_ready", 32'(bit_ready_o), 32'd1);
                check("resume_line", 32'(line_number_o), 32'(v.stall_slice + 1));
                post_stall = 0;
            end
            if (done_o) begin
                finished = 1;
                got_done = 1;
                if (v.exp_done != 0) check("done_cycle", k, v.exp_done);
                check("slice_count", rcv, 64);
                check("busy_at_done", 32'(busy_o), 32'd0);
                start_i     = 1'b1;  // must be ignored: DONE does not sample start
                bit_valid_i = 1'b0;
            end else if (v.abort && snd_slice == 17 && bit_idx == 12) begin
                finished    = 1;
                rst_ni      = 1'b0;
                bit_valid_i = 1'b0;
            end else begin
                slice_ready_i = 1'b1;
                if (slice_valid_o && !seen_hold) begin
                    seen_hold = 1;
                    held      = slice_out_o;
                    check("slice_data", 32'(slice_out_o), 32'(v.exp_slice));
                    check("line_number", 32'(line_number_o), rcv);
`ifdef SLICE_PARITY_EN
                    check("slice_parity", 32'(slice_parity_o), 32'(v.exp_par));
`endif
                end
                if (seen_hold && rcv == v.stall_slice && stall_cnt < v.stall_len) begin
                    slice_ready_i = 1'b0;
                    stall_cnt++;
                    check("stall_valid", 32'(slice_valid_o), 32'd1);
                    check("stall_stable", 32'(slice_out_o), 32'(held));
                    check("stall_bit_ready", 32'(bit_ready_o), 32'd0);
                    check("stall_line", 32'(line_number_o), 32'(v.stall_slice));
                end else if (slice_valid_o) begin
                    if (rcv == v.stall_slice) post_stall = 1;
                    rcv++;
                    seen_hold = 0;
                end
                bit_valid_i = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bit_in_i    = v.data[24 - bit_idx];
                if (bit_valid_i && bit_ready_o) begin
                    bit_idx++;
                    if (bit_idx == 25) begin
                        bit_idx = 0;
                        snd_slice++;
                    end
                end
            end
        end
        check("frame_finished", 32'(finished), 32'd1);
        if (got_done) begin
            @(negedge clk_i);
            start_i = 1'b0;
            check("done_pulse_len", 32'(done_o), 32'd0);
            check("start_at_done_busy", 32'(busy_o), 32'd0);
            check("start_at_done_bit_ready", 32'(bit_ready_o), 32'd0);
            check("line_wrap", 32'(line_number_o), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{25'h1555555, 1'b0, -1, 0, 1'b0, 1'b0, 25'h1555555, 1'b1, 1665};
        vecs[1] = '{25'h0ABCDEF, 1'b1, -1, 0, 1'b0, 1'b0, 25'h0ABCDEF, 1'b1, 0};
        vecs[2] = '{25'h1555555, 1'b0, 5, 10, 1'b0, 1'b0, 25'h1555555, 1'b1, 1675};
        vecs[3] = '{25'h0000001, 1'b0, -1, 0, 1'b0, 1'b0, 25'h0000001, 1'b1, 1665};
        vecs[4] = '{25'h0000003, 1'b0, -1, 0, 1'b1, 1'b0, 25'h0000003, 1'b0, 1665};
        abort_vec = '{25'h0ABCDEF, 1'b0, -1, 0, 1'b0, 1'b1, 25'h0ABCDEF, 1'b1, 0};

        // Reset with random inputs.
        rst_ni = 1'b0;
        start_i = 1'b0;
        bit_valid_i = 1'b0;
        bit_in_i = 1'b0;
        slice_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            start_i       = 1'($urandom_range(0, 1));
            bit_valid_i   = 1'($urandom_range(0, 1));
            bit_in_i      = 1'($urandom_range(0, 1));
            slice_ready_i = 1'($urandom_range(0, 1));
        end
        check("rst_bit_ready", 32'(bit_ready_o), 32'd0);
        check("rst_slice_valid", 32'(slice_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_slice_out", 32'(slice_out_o), 32'd0);
        check("rst_line", 32'(line_number_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        repeat (3) @(negedge clk_i);
        check("idle_bit_ready", 32'(bit_ready_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset mid-slice: abandon frame, then a fresh frame starts at line 0.
        run_frame(abort_vec);
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_slice_valid", 32'(slice_valid_o), 32'd0);
        check("abort_slice_out", 32'(slice_out_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_abort_bit_ready", 32'(bit_ready_o), 32'd0);
        check("post_abort_busy", 32'(busy_o), 32'd0);
        check("post_abort_line", 32'(line_number_o), 32'd0);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
